// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency data-memory port between the
// instruction-fetch requester and the load/store requester. Load/store has
// fixed priority. Every output comes straight from a flop.
//
// state | meaning
// IDLE  | no access in flight; accept a pending request (ls before if)
// ISSUE | one cycle: memory strobe and owner's grant asserted
// WAIT  | counting; reads wait for i_m_valid or timeout, writes wait MEM_LAT
// RESP  | one cycle: owner's valid/done pulse, then back to IDLE
module mem_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int INST_W  = 32,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_valid,
    output logic [INST_W-1:0] o_if_inst,
    input  logic              i_ls_req,
    input  logic              i_ls_we,
    input  logic [ADDR_W-1:0] i_ls_addr,
    input  logic [DATA_W-1:0] i_ls_wdata,
    output logic              o_ls_gnt,
    output logic              o_ls_done,
    output logic [DATA_W-1:0] o_ls_rdata,
    output logic [ADDR_W-1:0] o_m_addr,
    output logic [DATA_W-1:0] o_m_wdata,
    output logic              o_m_read,
    output logic              o_m_write,
    input  logic              i_m_valid,
    input  logic [DATA_W-1:0] i_m_rdata,
    output logic              o_busy,
    output logic              o_err
);

    // Wide enough to hold both the timeout and the write-latency terminal counts.
    localparam int CNT_W = $clog2(TIMEOUT + MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              own_ls, own_ls_nxt;
    logic              own_we, own_we_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              read_nxt, write_nxt;
    logic              if_gnt_nxt, ls_gnt_nxt;
    logic              if_valid_nxt, ls_done_nxt;
    logic [INST_W-1:0] if_inst_nxt;
    logic [DATA_W-1:0] ls_rdata_nxt;
    logic              err_nxt;
    logic              busy_nxt;

    // Register state, bookkeeping and every output; async reset clears all.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            own_ls     <= 1'b0;
            own_we     <= 1'b0;
            o_m_addr   <= '0;
            o_m_wdata  <= '0;
            o_m_read   <= 1'b0;
            o_m_write  <= 1'b0;
            o_if_gnt   <= 1'b0;
            o_ls_gnt   <= 1'b0;
            o_if_valid <= 1'b0;
            o_ls_done  <= 1'b0;
            o_if_inst  <= '0;
            o_ls_rdata <= '0;
            o_err      <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            own_ls     <= own_ls_nxt;
            own_we     <= own_we_nxt;
            o_m_addr   <= addr_nxt;
            o_m_wdata  <= wdata_nxt;
            o_m_read   <= read_nxt;
            o_m_write  <= write_nxt;
            o_if_gnt   <= if_gnt_nxt;
            o_ls_gnt   <= ls_gnt_nxt;
            o_if_valid <= if_valid_nxt;
            o_ls_done  <= ls_done_nxt;
            o_if_inst  <= if_inst_nxt;
            o_ls_rdata <= ls_rdata_nxt;
            o_err      <= err_nxt;
            o_busy     <= busy_nxt;
        end
    end

    // Next-state and next-output decode; pulses default low, data holds.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        own_ls_nxt   = own_ls;
        own_we_nxt   = own_we;
        addr_nxt     = o_m_addr;
        wdata_nxt    = o_m_wdata;
        read_nxt     = 1'b0;
        write_nxt    = 1'b0;
        if_gnt_nxt   = 1'b0;
        ls_gnt_nxt   = 1'b0;
        if_valid_nxt = 1'b0;
        ls_done_nxt  = 1'b0;
        if_inst_nxt  = o_if_inst;
        ls_rdata_nxt = o_ls_rdata;
        err_nxt      = o_err;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (i_ls_req) begin
                    own_ls_nxt = 1'b1;
                    own_we_nxt = i_ls_we;
                    addr_nxt   = i_ls_addr;
                    wdata_nxt  = i_ls_wdata;
                    read_nxt   = !i_ls_we;
                    write_nxt  = i_ls_we;
                    ls_gnt_nxt = 1'b1;
                    state_nxt  = ISSUE;
                end else if (i_if_req) begin
                    own_ls_nxt = 1'b0;
                    own_we_nxt = 1'b0;
                    addr_nxt   = i_if_addr;
                    wdata_nxt  = '0;
                    read_nxt   = 1'b1;
                    if_gnt_nxt = 1'b1;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_nxt   = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (own_we) begin
                    // Writes complete on latency alone; i_m_valid is not a completion here.
                    if (cnt == CNT_W'(MEM_LAT - 1)) begin
                        ls_done_nxt = 1'b1;
                        state_nxt   = RESP;
                    end
                end else if (i_m_valid || cnt == CNT_W'(TIMEOUT)) begin
                    // A timed-out read returns zero and latches the error.
                    if (!i_m_valid) begin
                        err_nxt = 1'b1;
                    end
                    if (own_ls) begin
                        ls_rdata_nxt = i_m_valid ? i_m_rdata : '0;
                        ls_done_nxt  = 1'b1;
                    end else begin
                        if_inst_nxt  = i_m_valid ? i_m_rdata[INST_W-1:0] : '0;
                        if_valid_nxt = 1'b1;
                    end
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected responses into
// a scoreboard queue, a negedge monitor pops and compares on every response pulse.
module tb_mem_port_arbiter;
    localparam int ADDR_W  = 64;
    localparam int INST_W  = 32;
    localparam int DATA_W  = 64;
    localparam int MEM_LAT = 8;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_gnt, if_valid;
    logic [INST_W-1:0] if_inst;
    logic              ls_req = 1'b0, ls_we = 1'b0;
    logic [ADDR_W-1:0] ls_addr = '0;
    logic [DATA_W-1:0] ls_wdata = '0;
    logic              ls_gnt, ls_done;
    logic [DATA_W-1:0] ls_rdata;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_read, m_write;
    logic              m_valid = 1'b0;
    logic [DATA_W-1:0] m_rdata = '0;
    logic              busy, err;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .INST_W(INST_W), .DATA_W(DATA_W),
        .MEM_LAT(MEM_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_if_req(if_req), .i_if_addr(if_addr),
        .o_if_gnt(if_gnt), .o_if_valid(if_valid), .o_if_inst(if_inst),
        .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
        .o_ls_gnt(ls_gnt), .o_ls_done(ls_done), .o_ls_rdata(ls_rdata),
        .o_m_addr(m_addr), .o_m_wdata(m_wdata), .o_m_read(m_read), .o_m_write(m_write),
        .i_m_valid(m_valid), .i_m_rdata(m_rdata),
        .o_busy(busy), .o_err(err)
    );

    always #5 clk = ~clk;

    // kind: 0 fetch, 1 load, 2 store (store expects o_ls_rdata unchanged)
    typedef struct {
        int          kind;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_read   = 0;
    int   n_write  = 0;
    int   n_resp   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic sig(input int k);
        case (k)
            0:       return if_gnt;
            1:       return ls_gnt;
            2:       return if_valid;
            default: return ls_done;
        endcase
    endfunction

    // Wait (at negedges) until the chosen output is high, bounded by max_cyc.
    task automatic wait_for(input int k, input int max_cyc, input string name, output int n);
        n = 0;
        while (!sig(k) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (!sig(k)) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: signal not seen within %0d cycles", name, n);
        end
    endtask

    // Memory model: d cycles after the current (ISSUE) cycle, one-cycle valid.
    task automatic mem_respond(input int d, input logic [63:0] data);
        repeat (d) @(negedge clk);
        m_valid = 1'b1;
        m_rdata = data;
        @(negedge clk);
        m_valid = 1'b0;
        m_rdata = '0;
    endtask

    // Monitor: strobe counting and scoreboard compare on every response pulse.
    always @(negedge clk) begin
        if (m_read)  n_read++;
        if (m_write) n_write++;
        if (if_valid || ls_done) begin
            n_resp++;
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_resp: if_valid=%0b ls_done=%0b with empty scoreboard", if_valid, ls_done);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.kind == 0) begin
                    check("resp_is_fetch", {63'd0, if_valid & ~ls_done}, 64'd1);
                    check("fetch_inst", {32'd0, if_inst}, {32'd0, mon_e.data[31:0]});
                end else begin
                    check("resp_is_ls", {63'd0, ls_done & ~if_valid}, 64'd1);
                    check("ls_rdata", ls_rdata, mon_e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    int n;
    int rd0, wr0, rs0;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_pulses", {58'd0, if_gnt, ls_gnt, if_valid, ls_done, m_read, m_write}, 64'd0);
        check("rst_addr", m_addr, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fetch only, memory answers 4 cycles after the read strobe
        sb.push_back('{0, 64'h0000_0000_00A0_0093});
        if_req = 1'b1; if_addr = 64'h40;
        wait_for(0, 10, "fetch_gnt", n);
        check("fetch_gnt_lat", 64'(n), 64'd1);
        check("fetch_read", {63'd0, m_read}, 64'd1);
        check("fetch_addr", m_addr, 64'h40);
        if_req = 1'b0;
        mem_respond(4, 64'h0000_0000_00A0_0093);
        check("fetch_valid_lat", {63'd0, if_valid}, 64'd1);
        @(negedge clk);
        check("fetch_idle", {63'd0, busy}, 64'd0);

        // Simultaneous requests: load wins, fetch follows after RESP
        rd0 = n_read;
        sb.push_back('{1, 64'h1122_3344_5566_7788});
        sb.push_back('{0, 64'hFFFF_FFFF_0000_0013});
        if_req = 1'b1; if_addr = 64'h80;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h100;
        wait_for(1, 10, "load_gnt", n);
        check("prio_ls_gnt_lat", 64'(n), 64'd1);
        check("prio_no_if_gnt", {63'd0, if_gnt}, 64'd0);
        check("load_addr", m_addr, 64'h100);
        ls_req = 1'b0;
        mem_respond(2, 64'h1122_3344_5566_7788);
        check("load_done", {63'd0, ls_done}, 64'd1);
        wait_for(0, 10, "pend_fetch_gnt", n);
        check("pend_fetch_gnt_lat", 64'(n), 64'd2);
        check("pend_fetch_addr", m_addr, 64'h80);
        if_req = 1'b0;
        mem_respond(1, 64'hFFFF_FFFF_0000_0013);
        @(negedge clk);
        check("one_read_per_access", 64'(n_read - rd0), 64'd2);

        // Store, with a stray i_m_valid and a withdrawn fetch request during WAIT
        rd0 = n_read; wr0 = n_write;
        sb.push_back('{2, 64'h1122_3344_5566_7788});
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 64'h18; ls_wdata = 64'hDEAD_BEEF;
        wait_for(1, 10, "store_gnt", n);
        check("store_write", {63'd0, m_write}, 64'd1);
        check("store_no_read", {63'd0, m_read}, 64'd0);
        check("store_wdata", m_wdata, 64'hDEAD_BEEF);
        check("store_addr", m_addr, 64'h18);
        ls_req = 1'b0; ls_we = 1'b0;
        n = 0;
        while (!ls_done && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 3) begin
                m_valid = 1'b1; m_rdata = 64'hBAD0_BAD0;
                if_req = 1'b1; if_addr = 64'h200;
            end else begin
                m_valid = 1'b0; m_rdata = '0;
                if_req = 1'b0;
            end
        end
        m_valid = 1'b0; if_req = 1'b0;
        check("store_done_lat", 64'(n), 64'd9);
        repeat (6) @(negedge clk);
        check("store_write_once", 64'(n_write - wr0), 64'd1);
        check("withdrawn_no_read", 64'(n_read - rd0), 64'd0);
        check("withdrawn_idle", {63'd0, busy}, 64'd0);

        // Load timeout
        sb.push_back('{1, 64'd0});
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h20;
        wait_for(1, 10, "to_gnt", n);
        check("to_err_before", {63'd0, err}, 64'd0);
        ls_req = 1'b0;
        wait_for(3, 40, "to_done", n);
        check("to_done_lat", 64'(n), 64'd17);
        check("to_err_set", {63'd0, err}, 64'd1);

        // Later fetch: normal, error stays set
        sb.push_back('{0, 64'h0000_0000_0000_0513});
        if_req = 1'b1; if_addr = 64'h48;
        wait_for(0, 10, "fetch2_gnt", n);
        check("fetch2_addr", m_addr, 64'h48);
        if_req = 1'b0;
        mem_respond(1, 64'h0000_0000_0000_0513);
        check("fetch2_valid", {63'd0, if_valid}, 64'd1);
        check("err_sticky", {63'd0, err}, 64'd1);
        @(negedge clk);

        // Reset mid-WAIT, then a late i_m_valid
        if_req = 1'b1; if_addr = 64'h300;
        wait_for(0, 10, "abort_gnt", n);
        if_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_err", {63'd0, err}, 64'd0);
        check("mid_rst_pulses", {58'd0, if_gnt, ls_gnt, if_valid, ls_done, m_read, m_write}, 64'd0);
        check("mid_rst_addr", m_addr, 64'd0);
        check("mid_rst_rdata", ls_rdata, 64'd0);
        check("mid_rst_inst", {32'd0, if_inst}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rs0 = n_resp;
        @(negedge clk);
        m_valid = 1'b1; m_rdata = 64'h0001_2345;
        @(negedge clk);
        m_valid = 1'b0; m_rdata = '0;
        repeat (4) @(negedge clk);
        check("late_valid_ignored", 64'(n_resp - rs0), 64'd0);
        check("late_valid_idle", {63'd0, busy}, 64'd0);

        // Fetch after reset proceeds normally
        sb.push_back('{0, 64'h0000_0000_0010_0073});
        if_req = 1'b1; if_addr = 64'h44;
        wait_for(0, 10, "fetch3_gnt", n);
        check("fetch3_gnt_lat", 64'(n), 64'd1);
        check("fetch3_addr", m_addr, 64'h44);
        if_req = 1'b0;
        mem_respond(3, 64'h0000_0000_0010_0073);
        check("fetch3_valid", {63'd0, if_valid}, 64'd1);
        repeat (2) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single data-memory port between the instruction-fetch requester (PC side) and the load/store requester (register/execute side) of the multi-cycle RISC-V core. The block sequences each access through a fixed-latency memory, delivering read data or write completion back to the winning requester. It also raises a stall indication for the PC controller. A sticky error flags reads that never return.

Parameters:
ADDR_W, 64, address width of both requesters and the memory port
INST_W, 32, instruction width returned to fetch (low bits of memory read data)
DATA_W, 64, memory data width
MEM_LAT, 8, cycles from the issue cycle to write completion
TIMEOUT, 15, maximum WAIT cycles allowed for a read before error

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset
i_if_req  in  1  fetch request; held until o_if_gnt
i_if_addr  in  ADDR_W  fetch address
o_if_gnt  out  1  one-cycle pulse: fetch request accepted
o_if_valid  out  1  one-cycle pulse: o_if_inst valid
o_if_inst  out  INST_W  fetched instruction
i_ls_req  in  1  load/store request; held until o_ls_gnt
i_ls_we  in  1  1=store, 0=load
i_ls_addr  in  ADDR_W  load/store address
i_ls_wdata  in  DATA_W  store data
o_ls_gnt  out  1  one-cycle pulse: load/store accepted
o_ls_done  out  1  one-cycle pulse: access complete; o_ls_rdata valid for loads
o_ls_rdata  out  DATA_W  load data
o_m_addr  out  ADDR_W  memory address
o_m_wdata  out  DATA_W  memory write data
o_m_read  out  1  memory read strobe
o_m_write  out  1  memory write strobe
i_m_valid  in  1  memory read data valid
i_m_rdata  in  DATA_W  memory read data
o_busy  out  1  high in any state other than IDLE
o_err  out  1  sticky read-timeout flag

Behaviour:
- Reset: i_rst_n is asynchronous, active-low; clock is i_clk. All outputs reset to 0, state to IDLE, counter to 0.
- All outputs are registered. States: IDLE, ISSUE, WAIT, RESP.
- IDLE: when i_ls_req or i_if_req is sampled high, latch owner/addr/we/wdata and go to ISSUE. Fixed priority: ls wins over if. The losing request stays pending.
- ISSUE (exactly 1 cycle): assert o_m_read (fetch, or load) or o_m_write (store) for this cycle only. o_m_addr/o_m_wdata are valid and remain stable until RESP ends. Pulse the owner's gnt in this cycle. Counter cleared. Next state is WAIT.
- WAIT: counter increments each cycle.
  - Read: first cycle with i_m_valid=1 captures i_m_rdata and goes to RESP.
  - Read with counter==TIMEOUT and no valid: set o_err, captured data = 0, go to RESP.
  - Write: when counter==MEM_LAT-1 (i.e. MEM_LAT cycles after ISSUE), go to RESP. i_m_valid is ignored.
- RESP (1 cycle):
  - Fetch: pulse o_if_valid, with o_if_inst = captured[INST_W-1:0].
  - Load: pulse o_ls_done, with o_ls_rdata = captured data.
  - Store: pulse o_ls_done; o_ls_rdata holds its previous value.
  - Next state is IDLE. No request is accepted in RESP; minimum spacing between ISSUE cycles is 4 cycles.
- i_m_valid outside WAIT, or during a write, is ignored. This includes stale responses arriving after reset.
- A request deasserted before its gnt is dropped without side effects.
- o_if_inst/o_ls_rdata hold their values between responses.
- o_err clears only on reset.
- Reset mid-access: the block returns to IDLE immediately. The memory strobe drops, and no done/valid pulse is produced for the aborted access.

Test Plan:
- Fetch only: i_if_req=1, addr=0x40, memory returns 0x00A00093 four cycles after the read strobe. Required: o_if_gnt at ISSUE; o_if_valid one cycle after i_m_valid with o_if_inst=0x00A00093; o_busy low afterwards.
- Simultaneous requests: i_if_req and i_ls_req (load addr 0x100) both high in IDLE. Required: load is served first; fetch gnt occurs in the ISSUE following the load's RESP; exactly one o_m_read per access.
- Store: we=1, addr=0x18, wdata=0xDEADBEEF, MEM_LAT=8. Required: o_m_write high for exactly 1 cycle; o_ls_done pulses 9 cycles after ISSUE; o_m_read never asserts.
- Timeout: load with i_m_valid held low. Required: o_err=1 after 16 WAIT cycles; o_ls_done pulses with o_ls_rdata=0; o_err stays 1 through later accesses.
- Reset mid-WAIT, then a late i_m_valid. Required: all outputs 0 and the block in IDLE; the late valid produces no o_if_valid or o_ls_done; the next fetch proceeds normally.
- Request withdrawn: i_if_req high for one cycle while a store is in WAIT. Required: no fetch issued after the store completes.
